// File: rtl/lsu_dcache_arb_pkg.sv
// Shared types for the LSU/DCache request arbiter: request and response payloads
// and the owner tag carried through the in-flight tracking FIFO.
package lsu_dcache_arb_pkg;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  rob_id;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iq_lsu_pkg_t;

  typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] rdata;
    logic        exc;
  } lsu_iq_pkg_t;

  typedef enum logic {
    OWNER_IQ = 1'b0,
    OWNER_SB = 1'b1
  } lsu_owner_e;

endpackage

// File: rtl/lsu_dcache_arb_if.sv
// Request/response channels around the DCache arbiter; the slave modport is the
// arbiter's view, the master modport is the surrounding LSU/DCache environment.
interface lsu_dcache_arb_if;
  import lsu_dcache_arb_pkg::*;

  logic        flush;
  logic        iq_valid_i;
  logic        iq_ready_o;
  iq_lsu_pkg_t iq_req_i;
  logic        sb_valid_i;
  logic        sb_ready_o;
  iq_lsu_pkg_t sb_req_i;
  logic        dc_valid_o;
  logic        dc_ready_i;
  iq_lsu_pkg_t dc_req_o;
  logic        dc_resp_valid_i;
  logic        dc_resp_ready_o;
  lsu_iq_pkg_t dc_resp_i;
  logic        iq_resp_valid_o;
  logic        iq_resp_ready_i;
  logic        sb_resp_valid_o;
  logic        sb_resp_ready_i;
  lsu_iq_pkg_t resp_o;
  logic        err_o;

  modport slave (
    input  flush, iq_valid_i, iq_req_i, sb_valid_i, sb_req_i, dc_ready_i,
           dc_resp_valid_i, dc_resp_i, iq_resp_ready_i, sb_resp_ready_i,
    output iq_ready_o, sb_ready_o, dc_valid_o, dc_req_o, dc_resp_ready_o,
           iq_resp_valid_o, sb_resp_valid_o, resp_o, err_o
  );

  modport master (
    output flush, iq_valid_i, iq_req_i, sb_valid_i, sb_req_i, dc_ready_i,
           dc_resp_valid_i, dc_resp_i, iq_resp_ready_i, sb_resp_ready_i,
    input  iq_ready_o, sb_ready_o, dc_valid_o, dc_req_o, dc_resp_ready_o,
           iq_resp_valid_o, sb_resp_valid_o, resp_o, err_o
  );

endinterface

// File: rtl/lsu_dcache_arb_owner_fifo.sv
// In-order FIFO of {owner, killed} for requests in flight at the DCache; a bulk
// kill marks every IQ-owned entry so its response is later dropped.
module lsu_owner_fifo
  import lsu_dcache_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  lsu_owner_e             push_owner,
  input  logic                   push_killed,
  input  logic                   pop,
  input  logic                   kill,
  output lsu_owner_e             head_owner,
  output logic                   head_killed,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lsu_owner_e       owner_r [DEPTH];
  logic [DEPTH-1:0] killed_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;

  // Storage, pointers and occupancy; a push after the kill loop keeps its own killed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        owner_r[i] <= OWNER_IQ;
      end
      killed_r <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && (owner_r[i] == OWNER_IQ)) begin
          killed_r[i] <= 1'b1;
        end
      end
      if (push) begin
        owner_r[wr_ptr_r]  <= push_owner;
        killed_r[wr_ptr_r] <= push_killed;
        wr_ptr_r           <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head_owner  = owner_r[rd_ptr_r];
  assign head_killed = killed_r[rd_ptr_r];
  assign empty       = (cnt_r == CW'(0));
  assign cnt         = cnt_r;

endmodule

// File: rtl/lsu_dcache_arb.sv
// Arbitrates LSU issue-queue and committed-store requests onto the single DCache port,
// tracks in-flight owners in order and steers responses back, dropping flushed IQ ones.
module lsu_dcache_arb
  import lsu_dcache_arb_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             rst,
  lsu_dcache_arb_if.slave bus
);

  localparam int CW = $clog2(OUTSTANDING) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          out_valid_r;
  lsu_owner_e    out_owner_r;
  iq_lsu_pkg_t   out_req_r;
  logic [SW-1:0] starve_cnt_r;
  logic          err_r;

  logic [CW-1:0] fifo_cnt_s;
  logic          fifo_empty_s;
  lsu_owner_e    head_owner_s;
  logic          head_killed_s;

  logic dc_fire_s;
  logic load_ok_s;
  logic starved_s;
  logic sb_wins_s;
  logic iq_wins_s;
  logic iq_ready_s;
  logic sb_ready_s;
  logic iq_load_s;
  logic sb_load_s;
  logic withdraw_s;
  logic push_killed_s;
  logic resp_pop_s;
  logic dc_resp_ready_s;
  logic iq_resp_valid_s;
  logic sb_resp_valid_s;

  assign dc_fire_s = out_valid_r & bus.dc_ready_i;
  // The slot for the request being loaded is reserved now; a same-cycle pop is not credited.
  assign load_ok_s = (~out_valid_r | dc_fire_s) &
                     ((fifo_cnt_s + CW'(dc_fire_s)) < CW'(OUTSTANDING));

  assign starved_s  = (starve_cnt_r == SW'(STARVE_LIMIT));
  assign sb_wins_s  = bus.sb_valid_i & (starved_s | ~bus.iq_valid_i);
  assign iq_wins_s  = bus.iq_valid_i & ~sb_wins_s;
  assign iq_ready_s = load_ok_s & ~bus.flush & iq_wins_s;
  assign sb_ready_s = load_ok_s & sb_wins_s;
  assign iq_load_s  = iq_ready_s & bus.iq_valid_i;
  assign sb_load_s  = sb_ready_s & bus.sb_valid_i;

  assign withdraw_s    = bus.flush & out_valid_r & (out_owner_r == OWNER_IQ) & ~dc_fire_s;
  assign push_killed_s = bus.flush & (out_owner_r == OWNER_IQ);

  // Output stage: load on grant, retire on fire, withdraw a pending IQ request on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_owner_r <= OWNER_IQ;
      out_req_r   <= '0;
    end else if (sb_load_s) begin
      out_valid_r <= 1'b1;
      out_owner_r <= OWNER_SB;
      out_req_r   <= bus.sb_req_i;
    end else if (iq_load_s) begin
      out_valid_r <= 1'b1;
      out_owner_r <= OWNER_IQ;
      out_req_r   <= bus.iq_req_i;
    end else if (dc_fire_s | withdraw_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Store-drain starvation counter: saturating count of lost arbitration cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (sb_load_s) begin
      starve_cnt_r <= '0;
    end else if (bus.sb_valid_i & ~sb_ready_s & ~starved_s) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end
  end

  // Sticky error: a response arrived with nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (bus.dc_resp_valid_i & fifo_empty_s) begin
      err_r <= 1'b1;
    end
  end

  // Response steering by FIFO head; killed or orphan responses are accepted and dropped.
  always_comb begin
    iq_resp_valid_s = 1'b0;
    sb_resp_valid_s = 1'b0;
    dc_resp_ready_s = 1'b1;
    if (fifo_empty_s | head_killed_s) begin
      dc_resp_ready_s = 1'b1;
    end else if (head_owner_s == OWNER_SB) begin
      sb_resp_valid_s = bus.dc_resp_valid_i;
      dc_resp_ready_s = bus.sb_resp_ready_i;
    end else begin
      iq_resp_valid_s = bus.dc_resp_valid_i;
      dc_resp_ready_s = bus.iq_resp_ready_i;
    end
  end

  assign resp_pop_s = bus.dc_resp_valid_i & dc_resp_ready_s & ~fifo_empty_s;

  lsu_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (dc_fire_s),
    .push_owner  (out_owner_r),
    .push_killed (push_killed_s),
    .pop         (resp_pop_s),
    .kill        (bus.flush),
    .head_owner  (head_owner_s),
    .head_killed (head_killed_s),
    .empty       (fifo_empty_s),
    .cnt         (fifo_cnt_s)
  );

  assign bus.iq_ready_o      = iq_ready_s;
  assign bus.sb_ready_o      = sb_ready_s;
  assign bus.dc_valid_o      = out_valid_r;
  assign bus.dc_req_o        = out_req_r;
  assign bus.dc_resp_ready_o = dc_resp_ready_s;
  assign bus.iq_resp_valid_o = iq_resp_valid_s;
  assign bus.sb_resp_valid_o = sb_resp_valid_s;
  assign bus.resp_o          = bus.dc_resp_i;
  assign bus.err_o           = err_r;

endmodule

// File: tb/tb_lsu_dcache_arb.sv
// Scoreboard bench for lsu_dcache_arb: a transaction-level model predicts grants,
// DCache requests and response routing; a monitor compares against the DUT.
module tb_lsu_dcache_arb;
  import lsu_dcache_arb_pkg::*;

  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_dcache_arb_if bus ();

  lsu_dcache_arb #(
    .OUTSTANDING (OUTSTANDING),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit own;   // 0 = IQ, 1 = SB
    bit kil;
  } ent_t;

  // Reference model state
  ent_t        fl_q[$];
  iq_lsu_pkg_t exp_req_q[$];
  lsu_iq_pkg_t exp_iq_q[$];
  lsu_iq_pkg_t exp_sb_q[$];
  bit          pend_v, pend_own, err_m;
  int          starve_m;
  bit          fire, stage_free, credit, sb_pick, iq_pick, sb_grant, iq_grant;
  bit          e_iq_ready, e_sb_ready, e_dc_valid, e_rr, e_iq_rv, e_sb_rv, e_err;
  ent_t        new_ent;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  function automatic iq_lsu_pkg_t rand_req();
    iq_lsu_pkg_t r;
    r.op     = 2'($urandom);
    r.rob_id = 6'($urandom);
    r.addr   = $urandom;
    r.wdata  = $urandom;
    return r;
  endfunction

  function automatic lsu_iq_pkg_t rand_resp();
    lsu_iq_pkg_t r;
    r.rob_id = 6'($urandom);
    r.rdata  = $urandom;
    r.exc    = 1'($urandom);
    return r;
  endfunction

  // Model: predicts this cycle's handshakes from the rules, then advances its state.
  always @(negedge clk) begin
    if (rst) begin
      pend_v = 1'b0; pend_own = 1'b0; err_m = 1'b0; starve_m = 0;
      fl_q.delete(); exp_req_q.delete(); exp_iq_q.delete(); exp_sb_q.delete();
    end else begin
      fire       = pend_v && bus.dc_ready_i;
      stage_free = !pend_v || fire;
      credit     = (fl_q.size() + (fire ? 1 : 0)) < OUTSTANDING;
      sb_pick    = bus.sb_valid_i && (starve_m == STARVE_LIMIT || !bus.iq_valid_i);
      iq_pick    = bus.iq_valid_i && !sb_pick;
      e_iq_ready = stage_free && credit && iq_pick && !bus.flush;
      e_sb_ready = stage_free && credit && sb_pick;
      e_dc_valid = pend_v;
      e_err      = err_m;
      e_iq_rv = 1'b0; e_sb_rv = 1'b0; e_rr = 1'b1;
      if (fl_q.size() != 0 && !fl_q[0].kil) begin
        if (fl_q[0].own) begin
          e_sb_rv = bus.dc_resp_valid_i; e_rr = bus.sb_resp_ready_i;
        end else begin
          e_iq_rv = bus.dc_resp_valid_i; e_rr = bus.iq_resp_ready_i;
        end
      end
      if (e_iq_rv && bus.iq_resp_ready_i) exp_iq_q.push_back(bus.dc_resp_i);
      if (e_sb_rv && bus.sb_resp_ready_i) exp_sb_q.push_back(bus.dc_resp_i);
      if (bus.dc_resp_valid_i && e_rr) begin
        if (fl_q.size() == 0) err_m = 1'b1;
        else void'(fl_q.pop_front());
      end
      if (bus.flush) foreach (fl_q[i]) if (!fl_q[i].own) fl_q[i].kil = 1'b1;
      if (fire) begin
        new_ent.own = pend_own;
        new_ent.kil = bus.flush && !pend_own;
        fl_q.push_back(new_ent);
      end
      sb_grant = e_sb_ready && bus.sb_valid_i;
      iq_grant = e_iq_ready && bus.iq_valid_i;
      if (sb_grant) begin
        pend_v = 1'b1; pend_own = 1'b1; exp_req_q.push_back(bus.sb_req_i);
      end else if (iq_grant) begin
        pend_v = 1'b1; pend_own = 1'b0; exp_req_q.push_back(bus.iq_req_i);
      end else if (fire) begin
        pend_v = 1'b0;
      end else if (bus.flush && pend_v && !pend_own) begin
        pend_v = 1'b0; void'(exp_req_q.pop_back());
      end
      if (sb_grant) starve_m = 0;
      else if (bus.sb_valid_i && starve_m < STARVE_LIMIT) starve_m++;
    end
  end

  // Monitor: compares DUT outputs with the predictions and pops the scoreboards on handshakes.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check("iq_ready", bus.iq_ready_o, e_iq_ready);
      check("sb_ready", bus.sb_ready_o, e_sb_ready);
      check("dc_valid", bus.dc_valid_o, e_dc_valid);
      check("dc_resp_ready", bus.dc_resp_ready_o, e_rr);
      check("iq_resp_valid", bus.iq_resp_valid_o, e_iq_rv);
      check("sb_resp_valid", bus.sb_resp_valid_o, e_sb_rv);
      check("err", bus.err_o, e_err);
      if (bus.dc_valid_o && bus.dc_ready_i) begin
        if (exp_req_q.size() == 0) fail_now("dc_req");
        else check("dc_req", bus.dc_req_o, exp_req_q.pop_front());
      end
      if (bus.iq_resp_valid_o && bus.iq_resp_ready_i) begin
        if (exp_iq_q.size() == 0) fail_now("iq_resp");
        else check("iq_resp", bus.resp_o, exp_iq_q.pop_front());
      end
      if (bus.sb_resp_valid_o && bus.sb_resp_ready_i) begin
        if (exp_sb_q.size() == 0) fail_now("sb_resp");
        else check("sb_resp", bus.resp_o, exp_sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0;
    bus.iq_valid_i = 1'b0; bus.iq_req_i = '0;
    bus.sb_valid_i = 1'b0; bus.sb_req_i = '0;
    bus.dc_ready_i = 1'b0;
    bus.dc_resp_valid_i = 1'b0; bus.dc_resp_i = '0;
    bus.iq_resp_ready_i = 1'b0; bus.sb_resp_ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_dc_valid"}, bus.dc_valid_o, 1'b0);
    check({tag, "_dc_req"}, bus.dc_req_o, 72'h0);
    check({tag, "_iq_ready"}, bus.iq_ready_o, 1'b0);
    check({tag, "_sb_ready"}, bus.sb_ready_o, 1'b0);
    check({tag, "_dc_resp_ready"}, bus.dc_resp_ready_o, 1'b1);
    check({tag, "_iq_resp_valid"}, bus.iq_resp_valid_o, 1'b0);
    check({tag, "_sb_resp_valid"}, bus.sb_resp_valid_o, 1'b0);
    check({tag, "_err"}, bus.err_o, 1'b0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    idle_inputs();
    bus.dc_ready_i = 1'b1; bus.iq_resp_ready_i = 1'b1; bus.sb_resp_ready_i = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      bus.dc_resp_valid_i = (fl_q.size() != 0);
      bus.dc_resp_i = rand_resp();
      tick();
      done = (fl_q.size() == 0) && !pend_v;
    end
    bus.dc_resp_valid_i = 1'b0;
    check("drain_done", done, 1'b1);
  endtask

  initial begin
    int  n_iq, n_g, n_iqv, n_sbv;
    bit  got_sb;
    rst = 1'b1;
    idle_inputs();
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // IQ only: grant at t0, request visible at t1, response routed to IQ
    bus.dc_ready_i = 1'b1; bus.iq_valid_i = 1'b1; bus.iq_req_i = rand_req();
    tick();
    bus.iq_valid_i = 1'b0;
    #1;
    check("iq_only_dc_valid", bus.dc_valid_o, 1'b1);
    tick();
    tick();
    bus.dc_resp_valid_i = 1'b1; bus.dc_resp_i = rand_resp(); bus.iq_resp_ready_i = 1'b1;
    #1;
    check("iq_only_iq_resp_valid", bus.iq_resp_valid_o, 1'b1);
    check("iq_only_sb_resp_valid", bus.sb_resp_valid_o, 1'b0);
    tick();
    drain();

    // Starvation: both requesters always valid, DCache always ready
    bus.iq_valid_i = 1'b1; bus.sb_valid_i = 1'b1;
    n_iq = 0; got_sb = 1'b0;
    for (int c = 0; c < 40 && !got_sb; c++) begin
      bus.dc_resp_valid_i = (fl_q.size() != 0);
      bus.iq_req_i = rand_req(); bus.sb_req_i = rand_req(); bus.dc_resp_i = rand_resp();
      #1;
      if (bus.sb_ready_o) got_sb = 1'b1;
      else if (bus.iq_ready_o) n_iq++;
      tick();
    end
    check("starve_iq_grants", n_iq, 8);
    check("starve_sb_granted", got_sb, 1'b1);
    bus.dc_resp_valid_i = (fl_q.size() != 0);
    #1;
    check("starve_cleared", {bus.iq_ready_o, bus.sb_ready_o}, 2'b10);
    tick();
    drain();

    // Credit limit: no responses, only OUTSTANDING requests issue
    bus.iq_valid_i = 1'b1;
    n_g = 0;
    for (int c = 0; c < 10; c++) begin
      bus.iq_req_i = rand_req();
      #1;
      if (bus.iq_ready_o) n_g++;
      tick();
    end
    check("credit_grants", n_g, OUTSTANDING);
    #1;
    check("credit_blocked", {bus.iq_ready_o, bus.sb_ready_o}, 2'b00);
    n_g = 0;
    for (int c = 0; c < 7; c++) begin
      bus.dc_resp_valid_i = (c == 0); bus.dc_resp_i = rand_resp();
      bus.iq_req_i = rand_req();
      #1;
      if (bus.iq_ready_o) n_g++;
      tick();
    end
    check("credit_one_more", n_g, 1);
    drain();

    // Flush with in-flight IQ, SB, IQ: only the SB response is delivered
    bus.dc_ready_i = 1'b1;
    bus.iq_valid_i = 1'b1; bus.iq_req_i = rand_req(); tick();
    bus.iq_valid_i = 1'b0; bus.sb_valid_i = 1'b1; bus.sb_req_i = rand_req(); tick();
    bus.sb_valid_i = 1'b0; bus.iq_valid_i = 1'b1; bus.iq_req_i = rand_req(); tick();
    bus.iq_valid_i = 1'b0; tick();
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    n_iqv = 0; n_sbv = 0;
    for (int c = 0; c < 3; c++) begin
      bus.dc_resp_valid_i = 1'b1; bus.dc_resp_i = rand_resp();
      #1;
      if (bus.iq_resp_valid_o) n_iqv++;
      if (bus.sb_resp_valid_o) n_sbv++;
      tick();
    end
    check("flush_mix_iq_resp", n_iqv, 0);
    check("flush_mix_sb_resp", n_sbv, 1);
    drain();

    // Flush while the output stage holds a request and DCache is stalled
    bus.dc_ready_i = 1'b0;
    bus.iq_valid_i = 1'b1; bus.iq_req_i = rand_req(); tick();
    bus.iq_valid_i = 1'b0; bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    #1;
    check("flush_withdraw_iq", bus.dc_valid_o, 1'b0);
    bus.sb_valid_i = 1'b1; bus.sb_req_i = rand_req(); tick();
    bus.sb_valid_i = 1'b0; bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    #1;
    check("flush_keeps_sb", bus.dc_valid_o, 1'b1);
    drain();

    // Spurious response: sticky error
    bus.dc_resp_valid_i = 1'b1; bus.dc_resp_i = rand_resp(); tick();
    bus.dc_resp_valid_i = 1'b0;
    #1;
    check("err_set", bus.err_o, 1'b1);
    repeat (3) tick();
    check("err_sticky", bus.err_o, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      bus.iq_valid_i      = ($urandom_range(0, 3) != 0);
      bus.iq_req_i        = rand_req();
      bus.sb_valid_i      = ($urandom_range(0, 2) == 0);
      bus.sb_req_i        = rand_req();
      bus.dc_ready_i      = ($urandom_range(0, 3) != 0);
      bus.dc_resp_valid_i = (fl_q.size() != 0) && ($urandom_range(0, 1) == 1);
      bus.dc_resp_i       = rand_resp();
      bus.iq_resp_ready_i = ($urandom_range(0, 3) != 0);
      bus.sb_resp_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush           = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Asynchronous reset mid-burst
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.iq_valid_i      = ($urandom_range(0, 1) == 1);
      bus.iq_req_i        = rand_req();
      bus.sb_valid_i      = ($urandom_range(0, 1) == 1);
      bus.sb_req_i        = rand_req();
      bus.dc_ready_i      = 1'b1;
      bus.dc_resp_valid_i = (fl_q.size() != 0);
      bus.dc_resp_i       = rand_resp();
      bus.iq_resp_ready_i = 1'b1;
      bus.sb_resp_ready_i = 1'b1;
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
